// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch entry inputs, decode head outputs,
// flush and occupancy. slave is the queue side, master the environment.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            valid_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instr_in;
    logic            predicted_taken_in;
    logic            flush_in;
    logic            stall_out;
    logic            valid_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instr_out;
    logic            predicted_taken_out;
    logic            ready_in;
    logic [CW-1:0]   count_out;

    modport slave (
        input  valid_in, pc_in, instr_in,
        input  predicted_taken_in, flush_in, ready_in,
        output stall_out, valid_out, pc_out,
        output instr_out, predicted_taken_out, count_out
    );

    modport master (
        output valid_in, pc_in, instr_in,
        output predicted_taken_in, flush_in, ready_in,
        input  stall_out, valid_out, pc_out,
        input  instr_out, predicted_taken_out, count_out
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode.
// Owns the fetch stall; a flush empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] INSTR_NOP = XLEN'(32'h0000_0013);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            pt;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    entry_t          head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign enq   = q.valid_in && !full && !q.flush_in;
    assign deq   = !empty && q.ready_in && !q.flush_in;

    // Storage needs no reset: nothing is visible while count is zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc:    q.pc_in,
                             instr: q.instr_in,
                             pt:    q.predicted_taken_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head = '{pc: '0, instr: INSTR_NOP, pt: 1'b0};
        if (!empty) head = mem[rd_ptr];
    end

    assign q.valid_out           = !empty;
    assign q.pc_out              = head.pc;
    assign q.instr_out           = head.instr;
    assign q.predicted_taken_out = head.pt;
    assign q.stall_out           = full;
    assign q.count_out           = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam logic [63:0] NOP = 64'h13;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
        logic        pt;
    } ent_t;

    logic clk;
    logic rst_n;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    ent_t exp_q[$];
    int   occ;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle of fetch/decode activity, then update the model.
    task automatic step(input bit v, input logic [63:0] pc,
                        input bit pt, input bit rdy, input bit fl);
        ent_t e;
        bit   enq;
        bit   deq;
        e.pc    = pc;
        e.instr = {$urandom, $urandom};
        e.pt    = pt;
        bus.valid_in           = v;
        bus.pc_in              = e.pc;
        bus.instr_in           = e.instr;
        bus.predicted_taken_in = pt;
        bus.ready_in           = rdy;
        bus.flush_in           = fl;
        @(posedge clk);
        enq = v && (occ < DEPTH) && !fl;
        deq = (occ > 0) && rdy && !fl;
        if (fl) begin
            exp_q.delete();
            occ = 0;
        end else begin
            if (enq) exp_q.push_back(e);
            occ = occ + int'(enq) - int'(deq);
        end
        #2;
    endtask

    // Monitor: compare the head whenever it is presented, pop on accept.
    always @(negedge clk) begin
        chk("count", 64'(bus.count_out), 64'(occ));
        chk("stall", 64'(bus.stall_out), 64'(occ == DEPTH));
        chk("valid", 64'(bus.valid_out), 64'(occ != 0));
        if (bus.valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head actual=pc %h required=no entry",
                         bus.pc_out);
            end else begin
                chk("head_pc", bus.pc_out, exp_q[0].pc);
                chk("head_instr", bus.instr_out, exp_q[0].instr);
                chk("head_pt", 64'(bus.predicted_taken_out),
                    64'(exp_q[0].pt));
                if (bus.ready_in && !bus.flush_in && rst_n)
                    void'(exp_q.pop_front());
            end
        end else begin
            chk("empty_pc", bus.pc_out, 64'h0);
            chk("empty_instr", bus.instr_out, NOP);
            chk("empty_pt", 64'(bus.predicted_taken_out), 64'h0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        occ    = 0;
        rst_n  = 1'b0;
        bus.valid_in           = 1'b0;
        bus.pc_in              = '0;
        bus.instr_in           = '0;
        bus.predicted_taken_in = 1'b0;
        bus.ready_in           = 1'b0;
        bus.flush_in           = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_out), 64'h0);
        chk("rst_instr", bus.instr_out, NOP);
        chk("rst_count", 64'(bus.count_out), 64'h0);
        chk("rst_stall", 64'(bus.stall_out), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Three enqueues, decode not ready
        for (int i = 0; i < 3; i++) step(1, 64'h100 + 64'(4 * i), 0, 0, 0);
        chk("t1_count", 64'(bus.count_out), 64'd3);
        chk("t1_pc", bus.pc_out, 64'h100);
        chk("t1_stall", 64'(bus.stall_out), 64'h0);

        // Fill, blocked 5th entry, dequeue from full, held entry enters
        step(1, 64'h10c, 0, 0, 0);
        chk("t2_stall", 64'(bus.stall_out), 64'h1);
        step(1, 64'h110, 1, 0, 0);
        chk("t2_blocked", 64'(bus.count_out), 64'd4);
        step(1, 64'h110, 1, 1, 0);
        chk("t2_deq_cnt", 64'(bus.count_out), 64'd3);
        chk("t2_deq_stall", 64'(bus.stall_out), 64'h0);
        step(1, 64'h110, 1, 0, 0);
        chk("t2_held_cnt", 64'(bus.count_out), 64'd4);
        for (int i = 0; i < 4; i++) step(0, 64'h0, 0, 1, 0);
        chk("t2_drained", 64'(bus.count_out), 64'd0);

        // Streaming with decode always ready
        for (int i = 0; i < 10; i++) begin
            step(1, 64'h200 + 64'(4 * i), i[0], 1, 0);
            chk("stream_cnt", 64'(bus.count_out <= 1), 64'h1);
        end
        step(0, 64'h0, 0, 1, 0);

        // Flush with simultaneous valid and ready
        for (int i = 0; i < 3; i++) step(1, 64'h300 + 64'(4 * i), 0, 0, 0);
        step(1, 64'h30c, 1, 1, 1);
        chk("flush_cnt", 64'(bus.count_out), 64'd0);
        chk("flush_valid", 64'(bus.valid_out), 64'h0);
        chk("flush_instr", bus.instr_out, NOP);
        step(0, 64'h0, 0, 1, 0);

        // Asynchronous reset between edges with two entries queued
        step(1, 64'h400, 0, 0, 0);
        step(1, 64'h404, 1, 0, 0);
        bus.valid_in = 1'b0;
        #1;
        rst_n = 1'b0;
        occ   = 0;
        exp_q.delete();
        #1;
        chk("arst_valid", 64'(bus.valid_out), 64'h0);
        chk("arst_count", 64'(bus.count_out), 64'h0);
        chk("arst_instr", bus.instr_out, NOP);
        chk("arst_pc", bus.pc_out, 64'h0);
        chk("arst_pt", 64'(bus.predicted_taken_out), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 64'h500, 1, 0, 0);
        chk("arst_new_pt", 64'(bus.predicted_taken_out), 64'h1);
        chk("arst_new_pc", bus.pc_out, 64'h500);
        step(0, 64'h0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7,
                 64'({$urandom, $urandom} & 64'hffff_fffc),
                 1'($urandom),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 64'h0, 0, 1, 0);
        chk("final_cnt", 64'(bus.count_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
